// File: rtl/game_pkg.sv
// Shared types and constants for the timed guessing round.
package game_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} round_state_t;

  // Galois feedback mask for x^8+x^6+x^5+x^4+1 (right-shifting form).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam int unsigned MAX_SECONDS = 99;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 8'h00);
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// Raw active-low pushbutton -> synchronised, debounced, single-cycle press strobe.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1, sync2;
  logic             stable;
  logic             press_q;
  logic [CNT_W-1:0] cnt;

  // Two-flop synchroniser; idle (released) level is 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive cycles; strobe once on an accepted 1->0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable  <= 1'b1;
      cnt     <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable  <= sync2;
        cnt     <= '0;
        press_q <= ~sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/round_controller.sv
// Timed game round: target generation, submit compare, countdown and GameOver.
module round_controller
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned GAME_SECONDS    = 60,
  parameter int unsigned TARGET_W        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_n,
  input  logic                submit_n,
  input  logic [TARGET_W-1:0] guess,
  output logic [TARGET_W-1:0] target,
  output logic                answer,
  output logic                wrong,
  output logic                GameOver,
  output logic [6:0]          time_left
);

  localparam int unsigned TICK_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [6:0]  SECS   = 7'(GAME_SECONDS);

  logic start_press, submit_press;

  round_state_t        state_q, state_d;
  logic [7:0]          lfsr_q;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [6:0]          time_q, time_d;
  logic [TARGET_W-1:0] target_q, target_d;
  logic                answer_q, answer_d;
  logic                wrong_q, wrong_d;
  logic                over_q, over_d;
  logic [TARGET_W-1:0] cand, new_target;
  logic                tick;

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_key (
    .clk  (clk),
    .rst  (rst),
    .key_n(start_n),
    .press(start_press)
  );

  key_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_submit_key (
    .clk  (clk),
    .rst  (rst),
    .key_n(submit_n),
    .press(submit_press)
  );

  // Free-running LFSR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // A freshly loaded target must differ from the one it replaces.
  assign cand       = lfsr_q[TARGET_W-1:0];
  assign new_target = (cand == target_q) ? ~cand : cand;
  assign tick       = (tick_q == TICK_W'(CLK_HZ - 1));

  // Round state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      time_q   <= SECS;
      target_q <= LFSR_SEED[TARGET_W-1:0];
      answer_q <= 1'b0;
      wrong_q  <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      time_q   <= time_d;
      target_q <= target_d;
      answer_q <= answer_d;
      wrong_q  <= wrong_d;
      over_q   <= over_d;
    end
  end

  // Next-state: start always (re)begins a round; the final tick wins over a submit.
  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    time_d   = time_q;
    target_d = target_q;
    answer_d = 1'b0;
    wrong_d  = 1'b0;
    over_d   = over_q;
    if (start_press) begin
      state_d  = PLAY;
      tick_d   = '0;
      time_d   = SECS;
      target_d = new_target;
      over_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, OVER: begin
          tick_d = '0;
        end
        PLAY: begin
          tick_d = tick ? '0 : tick_q + 1'b1;
          if (tick && time_q <= 7'd1) begin
            time_d  = 7'd0;
            over_d  = 1'b1;
            state_d = OVER;
          end else begin
            if (tick) begin
              time_d = time_q - 7'd1;
            end
            if (submit_press) begin
              if (guess == target_q) begin
                answer_d = 1'b1;
                target_d = new_target;
              end else begin
                wrong_d = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign target    = target_q;
  assign answer    = answer_q;
  assign wrong     = wrong_q;
  assign GameOver  = over_q;
  assign time_left = time_q;

endmodule

// File: tb/tb_round_controller.sv
// Self-checking bench for round_controller with a cycle-level reference model.
module tb_round_controller;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 3;
  localparam int GS     = 3;
  localparam int TW     = 4;
  localparam logic [7:0] SEED = 8'hA5;
  // Edges from driving a key low to the round logic acting on it:
  // two synchroniser flops, DEB stable samples, one strobe register.
  localparam int PRESS_LAT = 2 + DEB + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_n, submit_n;
  logic [TW-1:0] guess, target;
  logic          answer, wrong, GameOver;
  logic [6:0]    time_left;

  always #5 clk = ~clk;

  round_controller #(
    .CLK_HZ         (CLK_HZ),
    .GAME_SECONDS   (GS),
    .TARGET_W       (TW),
    .DEBOUNCE_CYCLES(DEB),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_n  (start_n),
    .submit_n (submit_n),
    .guess    (guess),
    .target   (target),
    .answer   (answer),
    .wrong    (wrong),
    .GameOver (GameOver),
    .time_left(time_left)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int n_ans = 0;
  int n_wrong = 0;

  // Reference model: phase 0 = waiting, 1 = running, 2 = finished.
  logic [7:0]     m_lfsr;
  logic [DEB-1:0] m_hs, m_hu;
  logic           m_ss, m_su;
  logic [2:0]     m_ps, m_pu;
  int             m_phase, m_elapsed;
  logic [TW-1:0]  m_target;
  logic           m_answer, m_wrong;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_time();
    if (m_phase == 0) return GS;
    if (m_phase == 2) return 0;
    return GS - m_elapsed / CLK_HZ;
  endfunction

  task automatic model_reset();
    m_lfsr    = SEED;
    m_hs      = '1;
    m_hu      = '1;
    m_ss      = 1'b1;
    m_su      = 1'b1;
    m_ps      = '0;
    m_pu      = '0;
    m_phase   = 0;
    m_elapsed = 0;
    m_target  = SEED[TW-1:0];
    m_answer  = 1'b0;
    m_wrong   = 1'b0;
  endtask

  // Advance the model across one clock edge using the pre-edge inputs.
  task automatic model_update();
    logic [DEB-1:0] nh;
    logic           ds, du, sp, sb;
    logic [TW-1:0]  cand, nt;
    sp = m_ps[2];
    sb = m_pu[2];
    ds = 1'b0;
    nh = {m_hs[DEB-2:0], start_n};
    if (nh == {DEB{~m_ss}}) begin
      m_ss = ~m_ss;
      ds   = ~m_ss;
    end
    m_hs = nh;
    m_ps = {m_ps[1:0], ds};
    du = 1'b0;
    nh = {m_hu[DEB-2:0], submit_n};
    if (nh == {DEB{~m_su}}) begin
      m_su = ~m_su;
      du   = ~m_su;
    end
    m_hu = nh;
    m_pu = {m_pu[1:0], du};
    cand = m_lfsr[TW-1:0];
    nt   = (cand == m_target) ? ~cand : cand;
    m_answer = 1'b0;
    m_wrong  = 1'b0;
    if (sp) begin
      m_phase   = 1;
      m_elapsed = 0;
      m_target  = nt;
    end else if (m_phase == 1) begin
      m_elapsed++;
      if (m_elapsed >= GS * CLK_HZ) begin
        m_phase = 2;
      end else if (sb) begin
        if (guess == m_target) begin
          m_answer = 1'b1;
          m_target = nt;
        end else begin
          m_wrong = 1'b1;
        end
      end
    end
    m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
  endtask

  task automatic check_outputs();
    chk("target", 32'(target), 32'(m_target));
    chk("answer", 32'(answer), 32'(m_answer));
    chk("wrong", 32'(wrong), 32'(m_wrong));
    chk("GameOver", 32'(GameOver), 32'(m_phase == 2));
    chk("time_left", 32'(time_left), 32'(exp_time()));
    chk("excl_pulses", 32'(answer & wrong), 32'd0);
    chk("pulse_in_over", 32'((answer | wrong) & GameOver), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
    #1;
    cyc++;
    if (answer) n_ans++;
    if (wrong) n_wrong++;
    check_outputs();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // which: 0 = start key, 1 = submit key.
  task automatic key_press(input bit which, input int low_cycles, input int high_cycles);
    if (which) submit_n = 1'b0;
    else start_n = 1'b0;
    steps(low_cycles);
    if (which) submit_n = 1'b1;
    else start_n = 1'b1;
    steps(high_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, w0, s;
    logic [TW-1:0] old_t;
    rst      = 1'b1;
    start_n  = 1'b1;
    submit_n = 1'b1;
    guess    = '0;
    model_reset();
    steps(3);
    chk("rst_target", 32'(target), 32'(SEED[TW-1:0]));
    chk("rst_time", 32'(time_left), 32'(GS));
    chk("rst_go", 32'(GameOver), 32'd0);
    rst = 1'b0;
    steps(2);

    // 1: start press begins the round with a new target.
    key_press(0, 5, 6);
    chk("t1_time", 32'(time_left), 32'(GS));
    chk("t1_go", 32'(GameOver), 32'd0);
    chk("t1_new_target", 32'(target != SEED[TW-1:0]), 32'd1);

    // 2: correct guess.
    a0 = n_ans; w0 = n_wrong; old_t = m_target;
    guess = m_target;
    key_press(1, 5, 6);
    chk("t2_answers", 32'(n_ans - a0), 32'd1);
    chk("t2_wrongs", 32'(n_wrong - w0), 32'd0);
    chk("t2_target_changed", 32'(target != old_t), 32'd1);

    // 3: wrong guess.
    a0 = n_ans; w0 = n_wrong; old_t = m_target;
    guess = m_target ^ 4'd1;
    key_press(1, 5, 6);
    chk("t3_answers", 32'(n_ans - a0), 32'd0);
    chk("t3_wrongs", 32'(n_wrong - w0), 32'd1);
    chk("t3_target_kept", 32'(target), 32'(old_t));

    // 4: long hold gives one pulse; 1-cycle glitches give none.
    key_press(0, 5, 6);
    a0 = n_ans; w0 = n_wrong;
    guess = m_target;
    key_press(1, 40, 6);
    chk("t4_hold_pulses", 32'((n_ans - a0) + (n_wrong - w0)), 32'd1);
    key_press(0, 5, 6);
    a0 = n_ans; w0 = n_wrong;
    for (int i = 0; i < 5; i++) key_press(1, 1, 3);
    chk("t4_glitch_pulses", 32'((n_ans - a0) + (n_wrong - w0)), 32'd0);

    // 5: countdown 3,2,1,0 at CLK_HZ spacing, then submits ignored.
    s = cyc + PRESS_LAT;
    start_n = 1'b0;
    steps(5);
    start_n = 1'b1;
    while (cyc < s + GS * CLK_HZ) begin
      step();
      if (cyc == s) chk("t5_t0", 32'(time_left), 32'd3);
      if (cyc == s + 10) chk("t5_t10", 32'(time_left), 32'd2);
      if (cyc == s + 20) chk("t5_t20", 32'(time_left), 32'd1);
      if (cyc == s + 29) chk("t5_go_early", 32'(GameOver), 32'd0);
    end
    chk("t5_t30", 32'(time_left), 32'd0);
    chk("t5_go", 32'(GameOver), 32'd1);
    a0 = n_ans; w0 = n_wrong;
    guess = m_target;
    key_press(1, 5, 6);
    chk("t5_over_pulses", 32'((n_ans - a0) + (n_wrong - w0)), 32'd0);

    // 6: start from OVER, then a correct submit landing on the final tick.
    s = cyc + PRESS_LAT;
    start_n = 1'b0;
    steps(5);
    start_n = 1'b1;
    while (cyc < s) step();
    chk("t6_restart_go", 32'(GameOver), 32'd0);
    chk("t6_restart_time", 32'(time_left), 32'(GS));
    while (cyc < s + GS * CLK_HZ - PRESS_LAT) step();
    a0 = n_ans; w0 = n_wrong;
    guess = m_target;
    submit_n = 1'b0;
    steps(5);
    submit_n = 1'b1;
    while (cyc < s + GS * CLK_HZ) step();
    chk("t6_late_answer", 32'(answer), 32'd0);
    chk("t6_late_wrong", 32'(wrong), 32'd0);
    chk("t6_late_go", 32'(GameOver), 32'd1);
    steps(4);
    chk("t6_late_pulses", 32'((n_ans - a0) + (n_wrong - w0)), 32'd0);

    // Asynchronous reset in the middle of a round.
    key_press(0, 5, 12);
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_answer", 32'(answer), 32'd0);
    chk("mid_rst_wrong", 32'(wrong), 32'd0);
    chk("mid_rst_go", 32'(GameOver), 32'd0);
    chk("mid_rst_time", 32'(time_left), 32'(GS));
    chk("mid_rst_target", 32'(target), 32'(SEED[TW-1:0]));
    steps(2);
    rst = 1'b0;
    steps(2);

    // Randomised rounds with random key timing (including too-short presses).
    for (int r = 0; r < 10; r++) begin
      key_press(0, $urandom_range(8, 2), $urandom_range(8, 3));
      for (int k = 0; k < 5; k++) begin
        if ($urandom_range(1, 0) == 1) guess = m_target;
        else guess = m_target ^ TW'($urandom_range(15, 1));
        key_press(1, $urandom_range(8, 1), $urandom_range(8, 1));
      end
    end
    steps(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
